control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter WDOG_MAX, default 32: SHALL set the maximum consecutive MWAIT cycles without READY.
REQ-002 Parameter ITER_MAX, default 255 (legal range 1..255): SHALL set the maximum loop iterations before error.
REQ-003 CLK  in  1: sole clock; all state SHALL update on the rising edge.
REQ-004 RESET  in  1: asynchronous, active-low reset.
REQ-005 START  in  1: run request; sampled in IDLE only.
REQ-006 ABORT  in  1: synchronous abort; sampled in every state.
REQ-007 FLAG  in  1: datapath loop-termination status.
REQ-008 READY  in  1: datapath multiplier-complete status.
REQ-009 SEL  out  8: datapath tristate enables.
REQ-010 MUX  out  4: datapath mux selects.
REQ-011 LOAD  out  7: datapath register loads; LOAD[6] is the multiplier start.
REQ-012 ENABLE  out  1: datapath counter increment.
REQ-013 VALID  out  1: datapath result-output gate.
REQ-014 BUSY  out  1: high in every state except IDLE.
REQ-015 DONE  out  1: single-cycle completion pulse.
REQ-016 ERR  out  1: sticky error flag.
REQ-017 ITERS  out  8: completed-iteration count.
REQ-018 STATE  out  3: current state code, for debug.

Function
REQ-019 The FSM SHALL use a 3-bit state register with codes IDLE=0, FETCH=1, MSTART=2, MWAIT=3, ACC=4, STEP=5, CHECK=6, FINISH=7.
REQ-020 SEL, MUX, LOAD, ENABLE, VALID, BUSY and DONE SHALL be Moore outputs decoded from the state register only, with no combinational input-to-output path.
REQ-021 The decode SHALL follow this table (SEL, MUX, LOAD, ENABLE, VALID):
- IDLE: 0x00, 0x0, 0x00, 0, 0
- FETCH: 0x00, 0x4, 0x01, 0, 0
- MSTART: 0x12, 0x0, 0x40, 0, 0
- MWAIT: 0x12, 0x0, 0x00, 0, 0
- ACC: 0x24, 0x8, 0x20, 0, 0
- STEP: 0x00, 0x0, 0x02, 1, 0
- CHECK: 0x80, 0x0, 0x00, 0, 0
- FINISH: 0x00, 0x0, 0x00, 0, 1
REQ-022 IDLE transitions:
- START=1: go to FETCH, clear ERR to 0 and ITERS to 0.
- Otherwise: stay in IDLE.
REQ-023 FETCH SHALL go to MSTART unconditionally; MSTART SHALL go to MWAIT unconditionally, so LOAD[6] is high exactly one cycle per iteration.
REQ-024 The watchdog counter SHALL clear on entry to MWAIT and count consecutive MWAIT cycles.
REQ-025 MWAIT transitions:
- READY=1: go to ACC.
- READY=0 in the WDOG_MAX-th consecutive MWAIT cycle: go to IDLE with ERR=1.
- Otherwise: stay in MWAIT.
REQ-026 ACC SHALL go to STEP; STEP SHALL go to CHECK; ITERS SHALL increment on exit from STEP, saturating at 255.
REQ-027 CHECK transitions:
- FLAG=1: go to FINISH.
- FLAG=0 and ITERS<ITER_MAX: go to MSTART.
- FLAG=0 and ITERS=ITER_MAX: go to IDLE with ERR=1.
REQ-028 FINISH SHALL go to IDLE; DONE SHALL be high during FINISH only; ERR SHALL be unchanged.
REQ-029 ABORT=1 SHALL force IDLE at the next edge from any state, overriding all other transitions; ERR and ITERS SHALL be held; ABORT and START together in IDLE SHALL stay in IDLE.
REQ-030 START while BUSY=1 SHALL be ignored, with no queueing.
REQ-031 Latency SHALL be as follows, with the cycle in which START is sampled counted as cycle 0:
- FETCH occurs in cycle 1.
- With READY high in the first MWAIT cycle and FLAG=1 at the first CHECK, DONE is high in cycle 7.
- Each additional iteration adds 5 cycles.
- Each extra MWAIT cycle adds 1 cycle.

Reset
REQ-032 RESET=0 SHALL immediately, without a clock edge, force IDLE, all outputs to 0, ERR=0, ITERS=0 and watchdog=0.
REQ-033 Reset asserted mid-run SHALL abandon the run with no DONE pulse; operation SHALL resume from IDLE at the first rising edge with RESET=1.

Verification
REQ-034 Single pass: 1-cycle START, READY=1 in MWAIT, FLAG=1 -> DONE high in cycle 7 only, ITERS=1, LOAD[6] pulsed once, ERR=0, BUSY low from cycle 8.
REQ-035 Three iterations: FLAG=0,0,1 at successive CHECKs, READY immediate -> DONE in cycle 17, ITERS=3, ENABLE pulsed 3 times, LOAD[6] pulsed 3 times.
REQ-036 Watchdog: READY held 0 -> IDLE after 32 MWAIT cycles, ERR=1, no DONE; the next START clears ERR in the cycle after it is sampled.
REQ-037 Watchdog boundary: READY first high in the 32nd MWAIT cycle -> ACC taken, ERR=0, run completes normally.
REQ-038 Iteration limit: ITER_MAX=3, FLAG held 0 -> IDLE after the 3rd CHECK, ERR=1, ITERS=3, no DONE.
REQ-039 Abort and reset:
- ABORT in MWAIT -> IDLE at the next edge, BUSY=0, no DONE.
- RESET low mid-ACC -> SEL/LOAD/MUX=0 without a clock edge.
- START in cycle 3 of a run -> no effect.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: sequencing FSM for a multiply-accumulate loop datapath.
// Outputs are a pure function of the state. They are registered from the
// next-state decode, so they change together with the state register and
// have no path from any input.
module control_unit #(
   parameter int unsigned WDOG_MAX = 32,
   parameter int unsigned ITER_MAX = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       flag,
   input  logic       ready,
   output logic [7:0] sel,
   output logic [3:0] mux,
   output logic [6:0] load,
   output logic       enable,
   output logic       valid,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] iters,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_MSTART = 3'd2;
   localparam logic [2:0] S_MWAIT  = 3'd3;
   localparam logic [2:0] S_ACC    = 3'd4;
   localparam logic [2:0] S_STEP   = 3'd5;
   localparam logic [2:0] S_CHECK  = 3'd6;
   localparam logic [2:0] S_FINISH = 3'd7;

   // Watchdog counts 0..WDOG_MAX-1; the last value marks the final allowed MWAIT cycle.
   localparam int unsigned     WDW       = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;
   localparam logic [WDW-1:0]  WDOG_LAST = WDW'(WDOG_MAX - 1);
   localparam logic [7:0]      ITER_LIM  = 8'(ITER_MAX);

   logic [2:0]     state_nxt;
   logic           err_nxt;
   logic [7:0]     iters_nxt;
   logic [WDW-1:0] wdog, wdog_nxt;
   logic [7:0]     sel_nxt;
   logic [3:0]     mux_nxt;
   logic [6:0]     load_nxt;
   logic           enable_nxt;
   logic           valid_nxt;
   logic           busy_nxt;
   logic           done_nxt;

   // Next state, sticky error, iteration count, watchdog and output decode.
   always_comb begin
      state_nxt = state;
      err_nxt   = err;
      iters_nxt = iters;
      wdog_nxt  = wdog;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
               err_nxt   = 1'b0;
               iters_nxt = 8'd0;
            end
         end
         S_FETCH:  state_nxt = S_MSTART;
         S_MSTART: begin
            state_nxt = S_MWAIT;
            wdog_nxt  = '0;
         end
         S_MWAIT: begin
            if (ready) begin
               state_nxt = S_ACC;
            end else if (wdog == WDOG_LAST) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end else begin
               wdog_nxt = wdog + WDW'(1);
            end
         end
         S_ACC:  state_nxt = S_STEP;
         S_STEP: begin
            state_nxt = S_CHECK;
            if (iters != 8'hFF) begin
               iters_nxt = iters + 8'd1;
            end
         end
         S_CHECK: begin
            if (flag) begin
               state_nxt = S_FINISH;
            end else if (iters < ITER_LIM) begin
               state_nxt = S_MSTART;
            end else begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase

      // Abort wins over everything and freezes the status registers.
      if (abort) begin
         state_nxt = S_IDLE;
         err_nxt   = err;
         iters_nxt = iters;
         wdog_nxt  = wdog;
      end

      sel_nxt    = 8'h00;
      mux_nxt    = 4'h0;
      load_nxt   = 7'h00;
      enable_nxt = 1'b0;
      valid_nxt  = 1'b0;
      case (state_nxt)
         S_FETCH: begin
            mux_nxt  = 4'h4;
            load_nxt = 7'h01;
         end
         S_MSTART: begin
            sel_nxt  = 8'h12;
            load_nxt = 7'h40;
         end
         S_MWAIT:  sel_nxt = 8'h12;
         S_ACC: begin
            sel_nxt  = 8'h24;
            mux_nxt  = 4'h8;
            load_nxt = 7'h20;
         end
         S_STEP: begin
            load_nxt   = 7'h02;
            enable_nxt = 1'b1;
         end
         S_CHECK:  sel_nxt   = 8'h80;
         S_FINISH: valid_nxt = 1'b1;
         default: begin
            sel_nxt = 8'h00;
         end
      endcase
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_FINISH);
   end

   // State register and its registered output decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         sel    <= 8'h00;
         mux    <= 4'h0;
         load   <= 7'h00;
         enable <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         sel    <= sel_nxt;
         mux    <= mux_nxt;
         load   <= load_nxt;
         enable <= enable_nxt;
         valid  <= valid_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   // Status registers: sticky error, iteration count, MWAIT watchdog.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err   <= 1'b0;
         iters <= 8'd0;
         wdog  <= '0;
      end else begin
         err   <= err_nxt;
         iters <= iters_nxt;
         wdog  <= wdog_nxt;
      end
   end

endmodule
